// File: rtl/mac_pkg.sv
// Shared widths, FSM state type and lane-extraction helper for the MAC
// operand sequencer.
package mac_pkg;

  localparam int DATA_W = 16;
  localparam int PROD_W = 32;
  localparam int MAC_W  = 34;
  localparam int ACC_W  = 40;
  localparam int LANES  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } mac_ctrl_state_t;

  // Lane 0 sits in the least significant 16 bits of a packed buffer word.
  function automatic logic [DATA_W-1:0] lane_of(input logic [LANES*DATA_W-1:0] word,
                                                input int                        idx);
    return word[idx*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/mac_ctrl_if.sv
// Output-word valid/ready channel between mac_ctrl (master) and the output
// writer (slave).
interface mac_ctrl_if;
  import mac_pkg::*;

  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);

endinterface

// File: rtl/tag_delay.sv
// Fixed-depth 1-bit shift register with synchronous clear; exposes the first
// stage and the exit stage of the issue-tag pipeline.
module tag_delay #(
  parameter int DEPTH = 6
) (
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic first_o,
  output logic last_o
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  // Shift the new tag in at stage 1 every cycle.
  always_comb begin
    sr_d = {sr_q[DEPTH-2:0], din};
  end

  // Tag register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      sr_q <= {DEPTH{1'b0}};
    end else begin
      sr_q <= sr_d;
    end
  end

  assign first_o = sr_q[0];
  assign last_o  = sr_q[DEPTH-1];

endmodule

// File: rtl/mac_ctrl.sv
// Operand sequencer and result collector for the 4-lane MAC: streams N_GROUPS
// operand groups, accumulates the matching results and offers one 40-bit sum.
module mac_ctrl
  import mac_pkg::*;
#(
  parameter int N_GROUPS = 4,
  parameter int MAC_LAT  = 4,
  parameter int ADDR_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       ifm_base,
  input  logic [ADDR_W-1:0]       w_base,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       ifm_addr,
  input  logic [LANES*DATA_W-1:0] ifm_rdata,
  output logic [ADDR_W-1:0]       w_addr,
  input  logic [LANES*DATA_W-1:0] w_rdata,
  output logic [DATA_W-1:0]       mac_ifm_0,
  output logic [DATA_W-1:0]       mac_ifm_1,
  output logic [DATA_W-1:0]       mac_ifm_2,
  output logic [DATA_W-1:0]       mac_ifm_3,
  output logic [DATA_W-1:0]       mac_w_0,
  output logic [DATA_W-1:0]       mac_w_1,
  output logic [DATA_W-1:0]       mac_w_2,
  output logic [DATA_W-1:0]       mac_w_3,
  input  logic [MAC_W-1:0]        mac_result,
  mac_ctrl_if.master              out_if
);

  localparam int TAG_DEPTH = 2 + MAC_LAT;
  localparam int CNT_W     = 7;
  localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(N_GROUPS - 1);

  mac_ctrl_state_t state_q, state_d;

  logic [ADDR_W-1:0] ifm_addr_q, ifm_addr_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [CNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0]  res_cnt_q, res_cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              out_valid_q, out_valid_d;

  logic [LANES-1:0][DATA_W-1:0] ifm_op_q, ifm_op_d;
  logic [LANES-1:0][DATA_W-1:0] w_op_q, w_op_d;

  logic tag_in_s;
  logic tag_rd_s;
  logic tag_res_s;

  assign tag_in_s = (state_q == ST_FETCH);

  // Stage 1 marks returning buffer data; the exit stage marks a valid MAC result.
  tag_delay #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_delay (
    .clk     (clk),
    .clr     (rst),
    .din     (tag_in_s),
    .first_o (tag_rd_s),
    .last_o  (tag_res_s)
  );

  // Next-state, address, operand and accumulator logic.
  always_comb begin
    state_d     = state_q;
    ifm_addr_d  = ifm_addr_q;
    w_addr_d    = w_addr_q;
    fetch_cnt_d = fetch_cnt_q;
    res_cnt_d   = res_cnt_q;
    acc_d       = acc_q;
    done_d      = 1'b0;

    // Operands are zero unless buffer data for an issued group is arriving.
    for (int l = 0; l < LANES; l++) begin
      if (tag_rd_s) begin
        ifm_op_d[l] = lane_of(ifm_rdata, l);
        w_op_d[l]   = lane_of(w_rdata, l);
      end else begin
        ifm_op_d[l] = {DATA_W{1'b0}};
        w_op_d[l]   = {DATA_W{1'b0}};
      end
    end

    if (tag_res_s) begin
      acc_d     = acc_q + {{(ACC_W-MAC_W){1'b0}}, mac_result};
      res_cnt_d = res_cnt_q + 7'd1;
    end else begin
      acc_d     = acc_q;
      res_cnt_d = res_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_FETCH;
          ifm_addr_d  = ifm_base;
          w_addr_d    = w_base;
          fetch_cnt_d = {CNT_W{1'b0}};
          res_cnt_d   = {CNT_W{1'b0}};
          acc_d       = {ACC_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (fetch_cnt_q == LAST_GRP) begin
          state_d = ST_DRAIN;
        end else begin
          fetch_cnt_d = fetch_cnt_q + 7'd1;
          ifm_addr_d  = ifm_addr_q + ADDR_W'(1);
          w_addr_d    = w_addr_q + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        if (tag_res_s && (res_cnt_q == LAST_GRP)) begin
          state_d = ST_OUT;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_OUT: begin
        if (out_valid_q && out_if.out_ready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d      = (state_d != ST_IDLE);
    out_valid_d = (state_d == ST_OUT);
  end

  // Control, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ifm_addr_q  <= {ADDR_W{1'b0}};
      w_addr_q    <= {ADDR_W{1'b0}};
      fetch_cnt_q <= {CNT_W{1'b0}};
      res_cnt_q   <= {CNT_W{1'b0}};
      acc_q       <= {ACC_W{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      ifm_op_q    <= {(LANES*DATA_W){1'b0}};
      w_op_q      <= {(LANES*DATA_W){1'b0}};
    end else begin
      state_q     <= state_d;
      ifm_addr_q  <= ifm_addr_d;
      w_addr_q    <= w_addr_d;
      fetch_cnt_q <= fetch_cnt_d;
      res_cnt_q   <= res_cnt_d;
      acc_q       <= acc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      ifm_op_q    <= ifm_op_d;
      w_op_q      <= w_op_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign ifm_addr = ifm_addr_q;
  assign w_addr   = w_addr_q;

  assign mac_ifm_0 = ifm_op_q[0];
  assign mac_ifm_1 = ifm_op_q[1];
  assign mac_ifm_2 = ifm_op_q[2];
  assign mac_ifm_3 = ifm_op_q[3];
  assign mac_w_0   = w_op_q[0];
  assign mac_w_1   = w_op_q[1];
  assign mac_w_2   = w_op_q[2];
  assign mac_w_3   = w_op_q[3];

  assign out_if.out_valid = out_valid_q;
  assign out_if.out_data  = acc_q;

endmodule

// File: doc/mac_ctrl.md
# mac_ctrl

Operand sequencer and result collector for the 4-lane `mac` datapath; it is the initiator that drives the MAC's `ifm_*`/`w_*` inputs and consumes its `result`. On `start` it streams `N_GROUPS` packed 4×16-bit groups from the IFM and weight buffers into the MAC. It tracks the MAC pipeline latency with a tag pipeline and accumulates the per-group 34-bit results into one 40-bit output word. The output is delivered on a valid/ready handshake to the output writer.

## Interface
Parameters:
- `N_GROUPS`, default 4: groups of 4 products summed per output; range 1..64.
- `MAC_LAT`, default 4: cycles from operands applied at the MAC inputs to the matching `result` (multiplier + acc + result register).
- `ADDR_W`, default 8: buffer address width.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1  clock.
  - `rst`  in  1  synchronous active-high reset.
- Command:
  - `start`  in  1  one-cycle request; ignored while `busy`.
  - `ifm_base`, `w_base`  in  ADDR_W each  start addresses, sampled with `start`.
  - `busy`  out  1  high from the cycle after an accepted `start` until the output handshake completes.
  - `done`  out  1  one-cycle pulse in the cycle after the output handshake.
- IFM buffer:
  - `ifm_addr`  out  ADDR_W  read address.
  - `ifm_rdata`  in  64  lanes [15:0]=0 .. [63:48]=3; 1-cycle read latency.
- Weight buffer:
  - `w_addr`  out  ADDR_W  read address.
  - `w_rdata`  in  64  same packing as `ifm_rdata`; 1-cycle read latency.
- MAC side:
  - `mac_ifm_0..3`, `mac_w_0..3`  out  16 each  registered operands.
  - `mac_result`  in  34  MAC result.
- Output:
  - `out_valid`  out  1  output word valid.
  - `out_ready`  in  1  downstream ready.
  - `out_data`  out  40  accumulated sum.

## Operation
- FSM states: IDLE, FETCH, DRAIN, OUT.
  - IDLE: `start` moves to FETCH and loads the address counters from the bases.
  - FETCH: drives `ifm_addr`=`ifm_base`+g and `w_addr`=`w_base`+g for g=0..N_GROUPS-1, one per cycle. After the last address it moves to DRAIN.
  - DRAIN: waits until N_GROUPS results have been accumulated, then moves to OUT.
  - OUT: holds `out_valid`=1 with `out_data` stable. `out_valid && out_ready` returns to IDLE and pulses `done`.
- Issue tag: each FETCH cycle injects a 1 into a tag shift register of depth 2+MAC_LAT. In every other cycle a 0 is injected.
- Operand registers:
  - Load lane data one cycle after the read, when the tag at stage 1 is set.
  - Otherwise load zero, so the MAC sees zeros when idle.
- Accumulation: when the tag exits the shift register, add `mac_result` to the accumulator and increment the result counter.
- Arithmetic:
  - All values are unsigned.
  - `mac_result` is zero-extended to 40 bits.
  - The accumulator is cleared on `start` acceptance and does not wrap for N_GROUPS ≤ 64.
- Boundaries:
  - `start` while `busy` has no effect.
  - N_GROUPS=1: FETCH lasts one cycle.
  - `out_ready` held high before OUT: the handshake completes in the first OUT cycle.
  - `rst` at any point: returns to IDLE and clears the tag pipe, counters, accumulator and operand registers. It does not pulse `done`.
- Reset values:
  - `busy`, `done`, `out_valid` = 0.
  - `out_data`, all `mac_*` operands = 0.
  - `ifm_addr`, `w_addr` = 0.

## Timing
- `start` is sampled at the clock edge ending cycle 0.
- For group g:
  - The address is driven in cycle 1+g.
  - `rdata` is valid in cycle 2+g.
  - The operands are visible in cycle 3+g.
  - `mac_result` is valid in cycle 3+g+MAC_LAT.
- `out_valid` first rises in cycle N_GROUPS+3+MAC_LAT. With the defaults that is cycle 11.
- Throughput: one output per N_GROUPS+4+MAC_LAT cycles with `out_ready` held high. The FSM does not overlap jobs.

## Structure
- Package `mac_pkg`:
  - `DATA_W`=16, `PROD_W`=32, `MAC_W`=34, `ACC_W`=40, `LANES`=4.
  - FSM state enum `mac_ctrl_state_t`.
- Sub-module `tag_delay`: a parameterised-depth 1-bit shift register with synchronous clear, used for the issue-tag pipeline.

## Test plan
All scenarios use N_GROUPS=4 and MAC_LAT=4, with a behavioural MAC model of exactly 4-cycle latency.
- Basic sum: all IFM lanes 1, all weight lanes 2, `out_ready`=1.
  - `out_data`=32 with `out_valid` in cycle 11.
  - `done` pulses in cycle 12.
- Maximum values: all lanes 0xFFFF.
  - `out_data`=0xFFFE00010, with no overflow.
- Backpressure: `out_ready`=0 for 10 cycles after `out_valid` rises.
  - `out_valid` and `out_data` are held stable.
  - `busy` stays 1.
  - A `start` pulse in this window is ignored (no second job).
- Address sequence: `ifm_base`=0x10, `w_base`=0x80.
  - Addresses 0x10..0x13 and 0x80..0x83 appear in cycles 1..4.
  - All `mac_*` operands are 0 outside cycles 3..6.
- Reset mid-operation: assert `rst` in cycle 5.
  - The next cycle shows all outputs at reset values.
  - A fresh `start` then produces the correct sum, with no residue from the aborted job.
- Back-to-back jobs: issue `start` in the cycle after `done`.
  - The second result is independent of the first.
  - The accumulator is cleared between jobs.
